// File: rtl/deck_ram_arbiter_pkg.sv
// Shared definitions for the deck RAM arbiter.
//   - Deck geometry (DECK_SIZE, ADDR_W, DATA_W) and requester count.
//   - Requester index constants for the loader, shuffler and dealer engines.
//   - Arbiter FSM state encoding.
//   - next_index(): round-robin successor of a requester index.
package deck_ram_arbiter_pkg;

    localparam int NUM_REQ   = 3;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 4;
    localparam int DECK_SIZE = 52;

    localparam int REQ_LOADER   = 0;
    localparam int REQ_SHUFFLER = 1;
    localparam int REQ_DEALER   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/deck_ram_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Scans req starting at rr_ptr (wrapping) and returns the first set bit.
//   req        in   per-requester request bits
//   rr_ptr     in   index with the highest priority this round
//   winner     out  one-hot winner (all zero when no request)
//   winner_idx out  index of the winner (0 when no request)
module deck_ram_arbiter_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic found;
    int   idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/deck_ram_arbiter.sv
// Deck RAM arbiter: shares the single-port deck RAM between the loader,
// shuffler and dealer engines with round-robin arbitration. A requester that
// holds lock keeps the bus so its multi-access swap sequence stays atomic.
//   clock, reset_n       clock and asynchronous active-low reset
//   req/lock/we          per-requester request, keep-ownership, write select
//   addr/wdata           packed per-requester address and write data
//   gnt                  one-hot, command of requester i accepted this cycle
//   rvalid/rdata         one-hot read return, shared read data (0 when idle)
//   err                  accepted command addressed beyond the deck
//   mem_addr/data/wren   RAM command pins, driven only while granting
//   mem_q                RAM read data, one cycle after the address
module deck_ram_arbiter #(
    parameter int NUM_REQ   = deck_ram_arbiter_pkg::NUM_REQ,
    parameter int ADDR_W    = deck_ram_arbiter_pkg::ADDR_W,
    parameter int DATA_W    = deck_ram_arbiter_pkg::DATA_W,
    parameter int DECK_SIZE = deck_ram_arbiter_pkg::DECK_SIZE
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    input  logic [NUM_REQ-1:0]         we,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       err,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic                       mem_wren,
    input  logic [DATA_W-1:0]          mem_q
);

    import deck_ram_arbiter_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;

    // Read-return tracking: one read can be in flight per cycle.
    logic                rvld_q, rvld_d;
    logic [IDX_W-1:0]    rowner_q, rowner_d;
    logic                roor_q, roor_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;

    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_data;
    logic                cmd_oor;

    deck_ram_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx)
    );

    // Command fields of the current owner.
    always_comb begin
        cmd_addr = addr[int'(owner_q)*ADDR_W +: ADDR_W];
        cmd_data = wdata[int'(owner_q)*DATA_W +: DATA_W];
        cmd_oor  = (int'(cmd_addr) >= DECK_SIZE);
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        gnt      = '0;
        err      = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        rvld_d   = 1'b0;
        rowner_d = owner_q;
        roor_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (|pick_onehot) begin
                    owner_d = pick_idx;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (req[owner_q]) begin
                    gnt[owner_q] = 1'b1;
                    mem_addr     = cmd_addr;
                    mem_data     = cmd_data;
                    // Out-of-range commands are accepted but never reach the RAM.
                    mem_wren     = we[owner_q] & ~cmd_oor;
                    err          = cmd_oor;
                    rvld_d       = ~we[owner_q];
                    roor_d       = cmd_oor;
                end
                // Dropping req ends ownership even when locked, without an access.
                if (!req[owner_q] || !lock[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = IDX_W'(next_index(int'(owner_q), NUM_REQ));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            rvld_q   <= 1'b0;
            rowner_q <= '0;
            roor_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            rvld_q   <= rvld_d;
            rowner_q <= rowner_d;
            roor_q   <= roor_d;
        end
    end

    // Read return: an out-of-range read reports valid with zero data.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (rvld_q) begin
            rvalid[rowner_q] = 1'b1;
            if (!roor_q) begin
                rdata = mem_q;
            end
        end
    end

endmodule

// File: tb/tb_deck_ram_arbiter.sv
// Directed testbench for deck_ram_arbiter with a write-first synchronous
// deck RAM model preloaded with ram[i] = (i + 4) mod 16.
module tb_deck_ram_arbiter;

    import deck_ram_arbiter_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [2:0]  req, lock, we, gnt, rvalid;
    logic [17:0] addr;
    logic [11:0] wdata;
    logic [3:0]  rdata, mem_data, mem_q;
    logic [5:0]  mem_addr;
    logic        err, mem_wren;
    logic        pl_en;
    logic [3:0]  ram [0:63];

    int checks   = 0;
    int failures = 0;

    deck_ram_arbiter dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .lock     (lock),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .err      (err),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wren (mem_wren),
        .mem_q    (mem_q)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (pl_en) begin
            for (int i = 0; i < 64; i++) ram[i] <= 4'(i + 4);
        end else if (mem_wren) begin
            ram[mem_addr] <= mem_data;
        end
        mem_q <= mem_wren ? mem_data : ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    logic [31:0] rr_exp [0:6];

    initial begin
        rr_exp[0] = 32'h1; rr_exp[1] = 32'h0; rr_exp[2] = 32'h2; rr_exp[3] = 32'h0;
        rr_exp[4] = 32'h4; rr_exp[5] = 32'h0; rr_exp[6] = 32'h1;

        reset_n = 1'b0; pl_en = 1'b1;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        #2;
        chk("rst_gnt",    32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata",  32'(rdata), 32'h0);
        chk("rst_err",    32'(err), 32'h0);
        chk("rst_wren",   32'(mem_wren), 32'h0);
        chk("rst_maddr",  32'(mem_addr), 32'h0);
        chk("rst_mdata",  32'(mem_data), 32'h0);
        tick; tick;
        pl_en = 1'b0;
        reset_n = 1'b1;

        // Single dealer read of address 5
        tick; req[REQ_DEALER] = 1'b1; addr[12 +: 6] = 6'd5;
        #1; chk("t1_idle_gnt", 32'(gnt), 32'h0);
        tick; #1;
        chk("t1_gnt", 32'(gnt), 32'h4);
        chk("t1_maddr", 32'(mem_addr), 32'd5);
        chk("t1_wren", 32'(mem_wren), 32'h0);
        chk("t1_err", 32'(err), 32'h0);
        tick; req = '0;
        #1;
        chk("t1_gnt_after", 32'(gnt), 32'h0);
        chk("t1_rvalid", 32'(rvalid), 32'h4);
        chk("t1_rdata", 32'(rdata), 32'd9);

        // Atomic swap of RAM[0] and RAM[36] by the shuffler, dealer waiting
        tick; req = 3'b110; lock[REQ_SHUFFLER] = 1'b1; addr[6 +: 6] = 6'd0;
        #1; chk("sw_idle_gnt", 32'(gnt), 32'h0);
        tick; #1;
        chk("sw_rd0_gnt", 32'(gnt), 32'h2);
        chk("sw_rd0_addr", 32'(mem_addr), 32'd0);
        tick; addr[6 +: 6] = 6'd36;
        #1;
        chk("sw_rd36_gnt", 32'(gnt), 32'h2);
        chk("sw_rd36_addr", 32'(mem_addr), 32'd36);
        chk("sw_rv0", 32'(rvalid), 32'h2);
        chk("sw_rd0_data", 32'(rdata), 32'd4);
        tick; we[REQ_SHUFFLER] = 1'b1; wdata[4 +: 4] = 4'd4;
        #1;
        chk("sw_wr36_gnt", 32'(gnt), 32'h2);
        chk("sw_wr36_wren", 32'(mem_wren), 32'h1);
        chk("sw_wr36_addr", 32'(mem_addr), 32'd36);
        chk("sw_wr36_data", 32'(mem_data), 32'd4);
        chk("sw_rd36_data", 32'(rdata), 32'd8);
        tick; addr[6 +: 6] = 6'd0; wdata[4 +: 4] = 4'd8; lock[REQ_SHUFFLER] = 1'b0;
        #1;
        chk("sw_wr0_gnt", 32'(gnt), 32'h2);
        chk("sw_wr0_wren", 32'(mem_wren), 32'h1);
        chk("sw_wr0_addr", 32'(mem_addr), 32'd0);
        chk("sw_wr0_data", 32'(mem_data), 32'd8);
        tick; req[REQ_SHUFFLER] = 1'b0; we = '0;
        #1; chk("sw_bubble_gnt", 32'(gnt), 32'h0);
        tick; #1;
        chk("sw_dealer_gnt", 32'(gnt), 32'h4);
        chk("sw_dealer_addr", 32'(mem_addr), 32'd5);
        tick; req = '0;
        #1;
        chk("sw_dealer_rv", 32'(rvalid), 32'h4);
        chk("sw_dealer_rdata", 32'(rdata), 32'd9);
        chk("sw_ram0", 32'(ram[0]), 32'd8);
        chk("sw_ram36", 32'(ram[36]), 32'd4);

        // Round robin from reset with all three requesting
        tick; reset_n = 1'b0;
        #1; chk("rr_rst_gnt", 32'(gnt), 32'h0);
        tick; reset_n = 1'b1; req = 3'b111; lock = '0; we = '0;
        addr = {6'd3, 6'd2, 6'd1};
        #1; chk("rr_idle_gnt", 32'(gnt), 32'h0);
        for (int c = 0; c < 7; c++) begin
            tick; #1;
            chk($sformatf("rr_gnt_%0d", c), 32'(gnt), rr_exp[c]);
        end

        // Out-of-range write then read by the loader
        tick; req = 3'b001; we = 3'b001; lock = 3'b001; addr[0 +: 6] = 6'd52; wdata[0 +: 4] = 4'd7;
        #1; chk("oor_idle_gnt", 32'(gnt), 32'h0);
        tick; #1;
        chk("oor_wr_gnt", 32'(gnt), 32'h1);
        chk("oor_wr_err", 32'(err), 32'h1);
        chk("oor_wr_wren", 32'(mem_wren), 32'h0);
        tick; we = '0; lock = '0; addr[0 +: 6] = 6'd61;
        #1;
        chk("oor_rd_gnt", 32'(gnt), 32'h1);
        chk("oor_rd_err", 32'(err), 32'h1);
        chk("oor_rd_wren", 32'(mem_wren), 32'h0);
        chk("oor_wr_norv", 32'(rvalid), 32'h0);
        tick; req = '0;
        #1;
        chk("oor_rv", 32'(rvalid), 32'h1);
        chk("oor_rdata", 32'(rdata), 32'h0);
        chk("oor_err_clr", 32'(err), 32'h0);
        chk("oor_ram52", 32'(ram[52]), 32'd8);

        // Locked shuffler releases by dropping req for one cycle
        tick; req = 3'b011; lock = 3'b010; addr[6 +: 6] = 6'd10; addr[0 +: 6] = 6'd2;
        #1; chk("drop_idle_gnt", 32'(gnt), 32'h0);
        tick; #1;
        chk("drop_own_gnt", 32'(gnt), 32'h2);
        chk("drop_own_addr", 32'(mem_addr), 32'd10);
        tick; req[REQ_SHUFFLER] = 1'b0;
        #1;
        chk("drop_gnt", 32'(gnt), 32'h0);
        chk("drop_wren", 32'(mem_wren), 32'h0);
        chk("drop_rv", 32'(rvalid), 32'h2);
        chk("drop_rdata", 32'(rdata), 32'd14);
        tick; req[REQ_SHUFFLER] = 1'b1;
        #1; chk("drop_bubble_gnt", 32'(gnt), 32'h0);
        tick; #1;
        chk("drop_loader_gnt", 32'(gnt), 32'h1);
        chk("drop_loader_addr", 32'(mem_addr), 32'd2);
        tick; req[REQ_LOADER] = 1'b0; addr[6 +: 6] = 6'd20;
        #1;
        chk("drop_rel_gnt", 32'(gnt), 32'h0);
        chk("drop_loader_rdata", 32'(rdata), 32'd6);

        // Reset during a locked write
        tick; #1;
        chk("mid_rd_gnt", 32'(gnt), 32'h2);
        chk("mid_rd_addr", 32'(mem_addr), 32'd20);
        tick; we[REQ_SHUFFLER] = 1'b1; wdata[4 +: 4] = 4'd3;
        #1;
        chk("mid_wr_gnt", 32'(gnt), 32'h2);
        chk("mid_wr_wren", 32'(mem_wren), 32'h1);
        chk("mid_rv_before", 32'(rvalid), 32'h2);
        chk("mid_rdata_before", 32'(rdata), 32'd8);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wren", 32'(mem_wren), 32'h0);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_rv", 32'(rvalid), 32'h0);
        chk("mid_rst_rdata", 32'(rdata), 32'h0);
        chk("mid_rst_maddr", 32'(mem_addr), 32'h0);
        tick; reset_n = 1'b1; req = 3'b011; lock = '0; we = '0;
        #1;
        chk("mid_idle_gnt", 32'(gnt), 32'h0);
        chk("mid_idle_rv", 32'(rvalid), 32'h0);
        tick; #1;
        chk("mid_restart_gnt", 32'(gnt), 32'h1);
        chk("mid_ram20", 32'(ram[20]), 32'd8);
        tick; req = '0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
